// File: rtl/sha2_pad_pkg.sv
// Shared types and constants for the SHA-2 message padder.
//   pad_state_t : padder phase (message data, marker word, zero fill, length field)
//   pad_flags_t : block/message framing flags carried alongside each output word
//   MARK_BYTE   : the single '1' bit that terminates the message, as a byte
//   len_bits()  : width of the trailing length field in bits
package sha2_pad_pkg;

  typedef enum logic [1:0] {
    DATA = 2'd0,
    MARK = 2'd1,
    ZERO = 2'd2,
    LEN  = 2'd3
  } pad_state_t;

  typedef struct packed {
    logic sob;
    logic eob;
    logic eom;
  } pad_flags_t;

  localparam logic [7:0] MARK_BYTE = 8'h80;

  function automatic int unsigned len_bits(input int unsigned w, input int unsigned lw);
    return w * lw;
  endfunction

endpackage

// File: rtl/sha2_pad_byte_merge.sv
// Combinational last-word formatter: keeps bytes 0..nbytes-1 of a big-endian
// word, places the 0x80 marker in byte nbytes and clears the bytes after it.
// When nbytes equals the word size every byte is kept and no marker fits.
//   word     : input message word, byte 0 in the MSBs
//   nbytes   : number of valid bytes in word
//   merged_c : formatted word
module sha2_pad_byte_merge
  import sha2_pad_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0]          word,
  input  logic [$clog2(WORD_W/8):0]  nbytes,
  output logic [WORD_W-1:0]          merged_c
);

  localparam int unsigned BYTES = WORD_W / 8;
  localparam int unsigned NB_W  = $clog2(BYTES) + 1;

  // Byte-by-byte select: keep, marker, or zero.
  always_comb begin
    merged_c = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (NB_W'(b) < nbytes) begin
        merged_c[WORD_W-1-8*b -: 8] = word[WORD_W-1-8*b -: 8];
      end else if (NB_W'(b) == nbytes) begin
        merged_c[WORD_W-1-8*b -: 8] = MARK_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha2_msg_padder.sv
// Streaming SHA-2 message padder. Passes message words through, then appends
// the 0x80 marker, zero fill and the big-endian message bit length so that
// the output is a whole number of BLOCK_WORDS-word blocks, framed with
// start-of-block / end-of-block / end-of-message flags.
//   clk, rst_n                      : clock, async active-low reset
//   in_data/in_valid/in_ready       : message word stream (byte 0 = MSBs)
//   in_last/in_nbytes               : final word marker and its valid byte count
//   out_data/out_valid/out_ready    : padded word stream (one register stage)
//   out_sob/out_eob/out_eom         : word 0 of block, last word of block, last word of message
module sha2_msg_padder
  import sha2_pad_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned LEN_WORDS   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [$clog2(WORD_W/8):0]    in_nbytes,
  output logic                         in_ready,
  output logic [WORD_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sob,
  output logic                         out_eob,
  output logic                         out_eom
);

  localparam int unsigned BYTES     = WORD_W / 8;
  localparam int unsigned NB_W      = $clog2(BYTES) + 1;
  localparam int unsigned IDX_W     = $clog2(BLOCK_WORDS);
  localparam int unsigned LEN_BITS  = len_bits(WORD_W, LEN_WORDS);
  localparam int unsigned CNT_W     = LEN_BITS - 3;
  localparam int unsigned LIDX_W    = (LEN_WORDS > 1) ? $clog2(LEN_WORDS) : 1;
  // Block position of the last word that is not part of the length field.
  localparam int unsigned LEN_START = BLOCK_WORDS - LEN_WORDS - 1;

  // Elaboration-time legality checks.
  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_msg_padder: WORD_W must be 32 or 64");
  end
  if (BLOCK_WORDS != 16) begin : g_bad_block_words
    $error("sha2_msg_padder: BLOCK_WORDS must be 16");
  end
  if (LEN_WORDS != 2) begin : g_bad_len_words
    $error("sha2_msg_padder: LEN_WORDS must be 2");
  end

  pad_state_t               state,    state_nxt;
  logic [IDX_W-1:0]         word_idx, word_idx_nxt;
  logic [CNT_W-1:0]         byte_cnt, byte_cnt_nxt;
  logic [LIDX_W-1:0]        len_idx,  len_idx_nxt;
  logic                     valid_nxt;
  logic [WORD_W-1:0]        data_nxt;
  pad_flags_t               out_flags, flags_nxt;

  logic                     load_c;
  logic [WORD_W-1:0]        merged_c;
  logic [LEN_WORDS-1:0][WORD_W-1:0] len_words_c;
  logic [LIDX_W-1:0]        len_sel_c;
  pad_state_t               fill_next_c;
  logic                     emit_c;
  logic                     eom_c;
  logic                     eob_c;
  logic [WORD_W-1:0]        word_c;

  // Output register may take a new word when empty or being drained.
  assign load_c   = !out_valid || out_ready;
  assign in_ready = rst_n && (state == DATA) && load_c;

  assign out_sob = out_flags.sob;
  assign out_eob = out_flags.eob;
  assign out_eom = out_flags.eom;

  sha2_pad_byte_merge #(
    .WORD_W (WORD_W)
  ) u_merge (
    .word     (in_data),
    .nbytes   (in_nbytes),
    .merged_c (merged_c)
  );

  // Length field in bits, split into words, most significant word first.
  assign len_words_c = {byte_cnt, 3'b000};
  assign len_sel_c   = LIDX_W'(LEN_WORDS - 1) - len_idx;

  // After a marker or zero word at the current index: length starts next
  // only if this was the last pre-length slot, otherwise keep zero filling
  // (possibly through a block wrap into an extra block).
  assign fill_next_c = (word_idx == IDX_W'(LEN_START)) ? LEN : ZERO;

  // Next-state, counters and output register contents.
  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    byte_cnt_nxt = byte_cnt;
    len_idx_nxt  = len_idx;
    valid_nxt    = out_valid;
    data_nxt     = out_data;
    flags_nxt    = out_flags;
    emit_c       = 1'b0;
    eom_c        = 1'b0;
    eob_c        = 1'b0;
    word_c       = '0;

    if (load_c) begin
      valid_nxt = 1'b0;
      case (state)
        DATA: begin
          if (in_valid) begin
            emit_c = 1'b1;
            if (in_last) begin
              byte_cnt_nxt = byte_cnt + CNT_W'(in_nbytes);
              if (in_nbytes < NB_W'(BYTES)) begin
                word_c    = merged_c;
                state_nxt = fill_next_c;
              end else begin
                word_c    = in_data;
                state_nxt = MARK;
              end
            end else begin
              byte_cnt_nxt = byte_cnt + CNT_W'(BYTES);
              word_c       = in_data;
            end
          end
        end
        MARK: begin
          emit_c                 = 1'b1;
          word_c[WORD_W-1 -: 8]  = MARK_BYTE;
          state_nxt              = fill_next_c;
        end
        ZERO: begin
          emit_c    = 1'b1;
          state_nxt = fill_next_c;
        end
        LEN: begin
          emit_c = 1'b1;
          word_c = len_words_c[len_sel_c];
          if (len_idx == LIDX_W'(LEN_WORDS - 1)) begin
            eom_c        = 1'b1;
            state_nxt    = DATA;
            byte_cnt_nxt = '0;
            len_idx_nxt  = '0;
          end else begin
            len_idx_nxt = len_idx + LIDX_W'(1);
          end
        end
        default: state_nxt = DATA;
      endcase

      if (emit_c) begin
        eob_c         = (word_idx == IDX_W'(BLOCK_WORDS - 1));
        valid_nxt     = 1'b1;
        data_nxt      = word_c;
        flags_nxt.sob = (word_idx == '0);
        flags_nxt.eob = eob_c;
        flags_nxt.eom = eom_c;
        word_idx_nxt  = eob_c ? '0 : word_idx + IDX_W'(1);
      end
    end
  end

  // State, counters and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DATA;
      word_idx  <= '0;
      byte_cnt  <= '0;
      len_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else begin
      state     <= state_nxt;
      word_idx  <= word_idx_nxt;
      byte_cnt  <= byte_cnt_nxt;
      len_idx   <= len_idx_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_flags <= flags_nxt;
    end
  end

  // A final word may not claim more bytes than the word holds.
  a_nbytes_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready && in_last) |-> (in_nbytes <= NB_W'(BYTES)));

endmodule
